mem_lsu_stage: RTL

- Successor MEM stage for the 5-stage MIPS pipeline. Sits between EX and WB.
- Owns the data-SRAM port: issues requests over a variable-latency addr_ok/data_ok handshake and raises a stall request while the access is outstanding.
- Adds sub-word load/store support (LB/LBU/LH/LHU/LW/SB/SH/SW), misalignment exceptions and load-aware forwarding.

---
 rtl/mem_lsu_stage_pkg.sv | 46 ++++
 rtl/mem_lsu_stage_align.sv | 61 ++++++
 rtl/mem_lsu_stage.sv | 127 ++++++++++++
 3 files changed

// File: rtl/mem_lsu_stage_pkg.sv
// Shared definitions for the MEM/LSU stage: bus widths, memory-op codes,
// LSU handshake states and the EX->MEM bus layout.
package mem_lsu_stage_pkg;

  localparam int EX_TO_MEM_WD = 106;
  localparam int MEM_TO_WB_WD = 104;
  localparam int STALL_W      = 6;

  typedef enum logic [3:0] {
    MEM_OP_NONE = 4'd0,
    MEM_OP_LB   = 4'd1,
    MEM_OP_LBU  = 4'd2,
    MEM_OP_LH   = 4'd3,
    MEM_OP_LHU  = 4'd4,
    MEM_OP_LW   = 4'd5,
    MEM_OP_SB   = 4'd9,
    MEM_OP_SH   = 4'd10,
    MEM_OP_SW   = 4'd11
  } mem_op_e;

  typedef enum logic [1:0] {
    LSU_IDLE      = 2'd0,
    LSU_WAIT_ADDR = 2'd1,
    LSU_WAIT_DATA = 2'd2,
    LSU_DONE      = 2'd3
  } lsu_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [3:0]  mem_op;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] store_data;
    logic [31:0] ex_result;
  } ex_to_mem_t;

  // Codes 8 and above are stores; any other non-zero code is a load.
  function automatic logic is_store(input logic [3:0] op);
    return op[3];
  endfunction

  function automatic logic is_load(input logic [3:0] op);
    return (op != MEM_OP_NONE) && !op[3];
  endfunction

endpackage

// File: rtl/mem_lsu_stage_align.sv
// Combinational byte-lane logic: store lane enables/replication, load
// extraction with sign/zero extension, and alignment checking.
module lsu_align
  import mem_lsu_stage_pkg::*;
(
  input  logic [3:0]  mem_op_i,
  input  logic [1:0]  addr_i,
  input  logic [31:0] store_data_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  wen_o,
  output logic [31:0] wdata_o,
  output logic [31:0] load_data_o,
  output logic        misaligned_o
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  assign byte_s = rdata_i[{addr_i, 3'b000} +: 8];
  assign half_s = rdata_i[{addr_i[1], 4'b0000} +: 16];

  // Per-op lane formatting and alignment check.
  always_comb begin
    wen_o        = 4'b0000;
    wdata_o      = 32'h0000_0000;
    load_data_o  = 32'h0000_0000;
    misaligned_o = 1'b0;
    case (mem_op_i)
      MEM_OP_LB:  load_data_o = {{24{byte_s[7]}}, byte_s};
      MEM_OP_LBU: load_data_o = {24'h00_0000, byte_s};
      MEM_OP_LH: begin
        misaligned_o = addr_i[0];
        load_data_o  = {{16{half_s[15]}}, half_s};
      end
      MEM_OP_LHU: begin
        misaligned_o = addr_i[0];
        load_data_o  = {16'h0000, half_s};
      end
      MEM_OP_LW: begin
        misaligned_o = (addr_i != 2'b00);
        load_data_o  = rdata_i;
      end
      MEM_OP_SB: begin
        wen_o   = 4'b0001 << addr_i;
        wdata_o = {4{store_data_i[7:0]}};
      end
      MEM_OP_SH: begin
        misaligned_o = addr_i[0];
        wen_o        = addr_i[1] ? 4'b1100 : 4'b0011;
        wdata_o      = {2{store_data_i[15:0]}};
      end
      MEM_OP_SW: begin
        misaligned_o = (addr_i != 2'b00);
        wen_o        = 4'b1111;
        wdata_o      = store_data_i;
      end
      default: misaligned_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/mem_lsu_stage.sv
// MEM pipeline stage: owns the data-SRAM addr_ok/data_ok port, stalls the
// pipe while an access is outstanding, and produces WB and forwarding data.
module mem_lsu_stage
  import mem_lsu_stage_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic [STALL_W-1:0]      stall,
  input  logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
  output logic                    data_sram_req,
  output logic [3:0]              data_sram_wen,
  output logic [31:0]             data_sram_addr,
  output logic [31:0]             data_sram_wdata,
  input  logic                    data_sram_addr_ok,
  input  logic                    data_sram_data_ok,
  input  logic [31:0]             data_sram_rdata,
  output logic                    stallreq_mem,
  output logic [MEM_TO_WB_WD-1:0] mem_to_wb_bus,
  output logic                    mem_we_o,
  output logic [4:0]              mem_waddr_o,
  output logic [31:0]             mem_wdata_o,
  output logic                    mem_fwd_valid_o
);

  ex_to_mem_t  bus_q;
  lsu_state_e  state_q, state_d;
  logic [31:0] rdata_q, rdata_d;
  logic        req_s, need_access_s, misaligned_s, data_done_s;
  logic [3:0]  wen_s;
  logic [31:0] wdata_s, load_data_s, load_rdata_s, rf_wdata_s;
  logic        rf_we_s, adel_s, ades_s, unused_stall_s;

  assign unused_stall_s = ^{stall[5], stall[2:0]};

  // Stage input register: stall[3] holds, stall[3]&!stall[4] inserts a bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus_q <= '0;
    end else if (stall[3] && !stall[4]) begin
      bus_q <= '0;
    end else if (!stall[3]) begin
      bus_q <= ex_to_mem_bus;
    end else begin
      bus_q <= bus_q;
    end
  end

  // LSU handshake state and captured read data.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= LSU_IDLE;
      rdata_q <= 32'h0000_0000;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
    end
  end

  // Next-state and request logic.
  always_comb begin
    state_d = state_q;
    rdata_d = rdata_q;
    req_s   = 1'b0;
    case (state_q)
      LSU_IDLE: begin
        if (need_access_s) begin
          req_s   = 1'b1;
          state_d = data_sram_addr_ok ? LSU_WAIT_DATA : LSU_WAIT_ADDR;
        end else begin
          state_d = LSU_IDLE;
        end
      end
      LSU_WAIT_ADDR: begin
        req_s   = 1'b1;
        state_d = data_sram_addr_ok ? LSU_WAIT_DATA : LSU_WAIT_ADDR;
      end
      LSU_WAIT_DATA: begin
        if (data_sram_data_ok) begin
          rdata_d = data_sram_rdata;
          state_d = stall[4] ? LSU_DONE : LSU_IDLE;
        end else begin
          state_d = LSU_WAIT_DATA;
        end
      end
      LSU_DONE: state_d = stall[4] ? LSU_DONE : LSU_IDLE;
      default:  state_d = LSU_IDLE;
    endcase
  end

  lsu_align u_align (
    .mem_op_i     (bus_q.mem_op),
    .addr_i       (bus_q.ex_result[1:0]),
    .store_data_i (bus_q.store_data),
    .rdata_i      (load_rdata_s),
    .wen_o        (wen_s),
    .wdata_o      (wdata_s),
    .load_data_o  (load_data_s),
    .misaligned_o (misaligned_s)
  );

  assign need_access_s = (bus_q.mem_op != MEM_OP_NONE) && !misaligned_s;
  assign data_done_s   = (state_q == LSU_WAIT_DATA) && data_sram_data_ok;
  // Raw rdata is only meaningful in the data_ok cycle; afterwards use the copy.
  assign load_rdata_s  = (state_q == LSU_DONE) ? rdata_q : data_sram_rdata;

  assign data_sram_req   = req_s;
  assign data_sram_wen   = need_access_s ? wen_s : 4'b0000;
  assign data_sram_addr  = {bus_q.ex_result[31:2], 2'b00};
  assign data_sram_wdata = wdata_s;

  assign stallreq_mem = need_access_s && !((state_q == LSU_DONE) || data_done_s);

  assign rf_we_s    = bus_q.rf_we && !misaligned_s;
  assign rf_wdata_s = is_load(bus_q.mem_op) ? load_data_s : bus_q.ex_result;
  assign adel_s     = misaligned_s && is_load(bus_q.mem_op);
  assign ades_s     = misaligned_s && is_store(bus_q.mem_op);

  assign mem_to_wb_bus = {bus_q.pc, rf_we_s, bus_q.rf_waddr, rf_wdata_s, adel_s, ades_s,
                          misaligned_s ? bus_q.ex_result : 32'h0000_0000};

  assign mem_we_o        = rf_we_s;
  assign mem_waddr_o     = bus_q.rf_waddr;
  assign mem_wdata_o     = rf_wdata_s;
  assign mem_fwd_valid_o = !(is_load(bus_q.mem_op) && need_access_s) || data_done_s ||
                           (state_q == LSU_DONE);

endmodule
